// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor control chain (encoder, PID and PWM stages).
package motor_pkg;

  localparam int CNT_W_DEF       = 12;
  localparam int SHIFT_DEF       = 8;
  localparam int DEAD_CYCLES_DEF = 64;

  typedef enum logic {
    RUN  = 1'b0,
    DEAD = 1'b1
  } pwm_state_t;

  // 33-bit magnitude so that -2^31 has a representable absolute value
  function automatic logic [32:0] abs33(input logic signed [31:0] v);
    logic signed [32:0] ext;
    ext = {v[31], v};
    return ext[32] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

endpackage

// File: rtl/motor_pwm_out_if.sv
// Control/status bundle between the PID stage and the PWM output stage.
interface motor_pwm_if
  import motor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic                    enable;
  logic signed [31:0]      u_in;
  logic        [CNT_W-1:0] top;
  logic                    pwm_out;
  logic                    dir_out;
  logic        [CNT_W-1:0] duty_out;
  logic                    sat_out;
  logic                    period_start;

  modport master (
    output enable, u_in, top,
    input  pwm_out, dir_out, duty_out, sat_out, period_start
  );

  modport slave (
    input  enable, u_in, top,
    output pwm_out, dir_out, duty_out, sat_out, period_start
  );

endinterface

// File: rtl/motor_pwm_out_saturate.sv
// Combinational scale / magnitude / clamp of the control effort against the PWM period.
module pwm_saturate
  import motor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [31:0]      u_in,
  input  logic        [CNT_W-1:0] top,
  output logic        [CNT_W-1:0] duty_req,
  output logic                    dir_req,
  output logic                    sat_req
);

  logic signed [31:0] scaled;
  logic        [32:0] mag;
  logic        [32:0] top_ext;

  assign scaled   = u_in >>> SHIFT;
  assign mag      = abs33(scaled);
  assign top_ext  = 33'(top);
  assign sat_req  = mag > top_ext;
  assign dir_req  = scaled[31];
  assign duty_req = sat_req ? top : CNT_W'(mag);

endmodule

// File: rtl/motor_pwm_out.sv
// PWM output stage: period counter, boundary-latched duty, and dead-time on direction reversal.
module motor_pwm_out
  import motor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SHIFT       = SHIFT_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  motor_pwm_if.slave bus
);

  localparam int                DEAD_W    = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  pwm_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0]  duty, duty_n;
  logic [DEAD_W-1:0] dead, dead_n;
  logic              dir, dir_n;
  logic              pend_dir, pend_dir_n;
  logic              sat, sat_n;
  logic              pwm, pwm_n;
  logic              start, start_n;

  logic [CNT_W-1:0]  duty_req;
  logic              dir_req;
  logic              sat_req;
  logic              boundary;

  pwm_saturate #(
    .CNT_W (CNT_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .u_in     (bus.u_in),
    .top      (bus.top),
    .duty_req (duty_req),
    .dir_req  (dir_req),
    .sat_req  (sat_req)
  );

  // Using >= rather than == keeps the counter safe when top drops below cnt mid-period
  assign boundary = bus.enable && (cnt >= bus.top);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      duty     <= '0;
      dead     <= '0;
      dir      <= 1'b0;
      pend_dir <= 1'b0;
      sat      <= 1'b0;
      pwm      <= 1'b0;
      start    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      duty     <= duty_n;
      dead     <= dead_n;
      dir      <= dir_n;
      pend_dir <= pend_dir_n;
      sat      <= sat_n;
      pwm      <= pwm_n;
      start    <= start_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    duty_n     = duty;
    dead_n     = dead;
    dir_n      = dir;
    pend_dir_n = pend_dir;
    sat_n      = sat;
    pwm_n      = bus.enable && (state == RUN) && (cnt < duty);
    // While idle the counter sits at 0, so the first enabled cycle is a period start
    start_n    = boundary || !bus.enable;

    if (!bus.enable) begin
      state_n = RUN;
      cnt_n   = '0;
      duty_n  = '0;
      dead_n  = '0;
      sat_n   = 1'b0;
    end else begin
      cnt_n = (cnt >= bus.top) ? '0 : cnt + 1'b1;
      case (state)
        RUN: begin
          if (boundary) begin
            sat_n = sat_req;
            if (duty_req == '0) begin
              duty_n = '0;
            end else if (dir_req == dir) begin
              duty_n = duty_req;
            end else begin
              duty_n     = '0;
              pend_dir_n = dir_req;
              dead_n     = DEAD_LOAD;
              state_n    = DEAD;
            end
          end
        end
        DEAD: begin
          if (dead == '0) begin
            dir_n   = pend_dir;
            state_n = RUN;
          end else begin
            dead_n = dead - 1'b1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign bus.pwm_out      = pwm;
  assign bus.dir_out      = dir;
  assign bus.duty_out     = duty;
  assign bus.sat_out      = sat;
  assign bus.period_start = start && bus.enable;

  a_dead_duty_zero : assert property (@(posedge clk) disable iff (reset)
    (state == DEAD) |-> (duty == '0));

  a_idle_pwm_low : assert property (@(posedge clk) disable iff (reset)
    !bus.enable |=> !pwm);

endmodule

// File: doc/motor_pwm_out.md
# motor_pwm_out

Downstream stage of the PID controller. Converts the signed 32-bit control effort into a registered PWM waveform plus a direction bit for the H-bridge. The block scales the effort by a fixed arithmetic shift, saturates it to the PWM period, and latches the duty only at period boundaries. Every direction reversal inserts a dead-time with the output held low.

## Interface
Parameters:
- CNT_W, 12, width of the PWM counter and of duty/top values
- SHIFT, 8, arithmetic right shift applied to u_in before saturation
- DEAD_CYCLES, 64, clk cycles PWM is forced low on a direction reversal (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  high = run; low = idle, counter held at 0, output low
- u_in  in  32 signed  control effort from PID (u_out)
- top  in  CNT_W  counter terminal value; period = top+1 cycles
- pwm_out  out  1  registered PWM to bridge
- dir_out  out  1  registered direction: 1 = negative effort
- duty_out  out  CNT_W  duty currently applied
- sat_out  out  1  latched effort exceeded top at last boundary
- period_start  out  1  one-cycle pulse when counter is 0

## Operation
- Reset: cnt=0, state=RUN, duty_out=0, dir_out=0, pwm_out=0, sat_out=0, period_start=0, dead counter=0.
- Scaling: s = u_in >>> SHIFT (sign-preserving). mag = |s| computed in 33 bits, so u_in = -2^31 is handled without overflow. duty_req = min(mag, top). sat_req = (mag > top). dir_req = s < 0.
- Counter: when enable=1, cnt increments. cnt ≥ top at a clock edge → cnt=0 next cycle. This also makes a mid-period reduction of top safe.
- Boundary = enable && cnt ≥ top. Effort is sampled only at a boundary.
- FSM states RUN and DEAD.
  - RUN, boundary, duty_req=0: duty_out←0, dir_out unchanged.
  - RUN, boundary, dir_req==dir_out: duty_out←duty_req, sat_out←sat_req.
  - RUN, boundary, dir_req≠dir_out, duty_req≠0: duty_out←0, pending_dir←dir_req, dead←DEAD_CYCLES-1, go to DEAD.
  - DEAD: decrement dead each cycle. Boundaries are ignored and duty_out stays 0. At dead==0: dir_out←pending_dir, go to RUN. A non-zero duty is applied at the next boundary after that.
- pwm_out next = enable && state==RUN && (cnt < duty_out). duty=top gives top high cycles per top+1.
- enable low: cnt←0, duty_out←0, pwm_out←0, state←RUN, dead←0, dir_out held, sat_out←0.
- reset mid-DEAD: all outputs return to reset values and dir_out→0. No dead-time is inserted by reset itself, because pwm is already 0.

## Timing
- pwm_out lags the counter compare by 1 cycle (registered).
- Effort sampled at the boundary cycle. The new duty_out is visible the next cycle, together with cnt=0 and period_start=1. The first affected pwm_out high occurs one cycle after that.
- u_in → pwm_out worst-case latency: top+2 cycles.
- Reversal: pwm low from the boundary for ≥ DEAD_CYCLES cycles. dir_out toggles DEAD_CYCLES cycles after the boundary. New-direction drive begins at the next boundary.
- Single-cycle scale/abs/clamp path between u_in and the duty register; no internal pipeline.

## Structure
- Shared package motor_pkg holds the CNT_W default, the state enum (RUN, DEAD) and the default SHIFT/DEAD_CYCLES constants. The same package is reused by the encoder/PID stages.
- One combinational sub-module, pwm_saturate (u_in, top → duty_req, dir_req, sat_req), is isolated for unit test.
- The top level holds the counter, FSM, dead counter and output registers.

## Test plan
- top=99, SHIFT=8, u_in=50·256 → duty_out=50 and pwm_out high exactly 50 of every 100 cycles; dir_out=0, sat_out=0.
- u_in=500·256 → duty_out=99, sat_out=1. u_in=-2^31 → duty_out=99, dir_out=1 after dead-time, no overflow.
- Running at +30·256, step u_in to -30·256 → pwm low from that boundary. dir_out=1 exactly 64 cycles later; duty 30 starts at the following boundary.
- enable dropped mid-period → next cycle cnt=0, pwm_out=0, duty_out=0. Re-enable → period_start on the first enabled cycle.
- top changed 99→20 while cnt=50 → cnt wraps to 0 on the next cycle and the period becomes 21 thereafter.
- reset asserted during DEAD → all outputs equal reset values on the next cycle. After reset release with u_in=+10·256, duty 10 is applied at the first boundary.
